// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified RAM port between instruction fetch and load/store.
// MEM wins ties unless IF has been starved for STARVE_LIMIT grants; hung accesses abort with bus_err.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_ack,
  output logic          bus_err,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_ready,
  output logic          addr_sel,
  output logic          stall_if,
  output logic          stall_mem
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
  localparam logic [7:0] TmoLast   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusyIf, StBusyMem} state_e;

  state_e     state_q;
  logic [3:0] starve_q;
  logic [7:0] tmo_q;
  logic       grant_if, grant_mem;

  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (state_q == StIdle) begin
      if (mem_req && (starve_q < StarveMax)) begin
        grant_mem = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end else if (mem_req) begin
        grant_mem = 1'b1;
      end
    end
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = mem_req & ~mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      starve_q  <= 4'd0;
      tmo_q     <= 8'd0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      addr_sel  <= 1'b0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      bus_err   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      bus_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_mem || grant_if) begin
            state_q  <= grant_mem ? StBusyMem : StBusyIf;
            ram_en   <= 1'b1;
            ram_we   <= grant_mem & mem_we;
            ram_addr <= grant_mem ? mem_addr : if_addr;
            addr_sel <= grant_mem;
            tmo_q    <= 8'd0;
            if (grant_mem) begin
              ram_wdata <= mem_wdata;
            end
            if (grant_if) begin
              starve_q <= 4'd0;
            end else if (if_req && (starve_q != StarveMax)) begin
              starve_q <= starve_q + 4'd1;
            end
          end
        end
        StBusyIf, StBusyMem: begin
          // ram_ready in the last allowed cycle still counts as a normal completion
          if (ram_ready || (tmo_q == TmoLast)) begin
            state_q <= StIdle;
            ram_en  <= 1'b0;
            ram_we  <= 1'b0;
            bus_err <= ~ram_ready;
            if (state_q == StBusyIf) begin
              if_ack   <= 1'b1;
              if_rdata <= ram_ready ? ram_rdata : '0;
            end else begin
              mem_ack <= 1'b1;
              if (!ram_we) begin
                mem_rdata <= ram_ready ? ram_rdata : '0;
              end
            end
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
